// File: rtl/rgb2ycbcr_pipe.sv
// rgb2ycbcr_pipe: 4-stage RGB->YCbCr converter (JFIF full / BT.601 studio range) with
// valid/ready flow control as a global stall; the range is latched per frame on an accepted SOF.
module rgb2ycbcr_pipe #(
   parameter int DATA_W       = 8,
   parameter int COEF_FRAC    = 8,
   parameter bit DEFAULT_FULL = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_full_range,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_r,
   input  logic [DATA_W-1:0] s_g,
   input  logic [DATA_W-1:0] s_b,
   input  logic              s_sof,
   input  logic              s_eol,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_y,
   output logic [DATA_W-1:0] m_cb,
   output logic [DATA_W-1:0] m_cr,
   output logic              m_sof,
   output logic              m_eol
);
   localparam int AW     = DATA_W + COEF_FRAC + 3;
   localparam int HALF   = 2 ** (COEF_FRAC - 1);
   localparam int OFF_C  = ((128 << (DATA_W - 8)) << COEF_FRAC) + HALF;
   localparam int OFF_YS = ((16 << (DATA_W - 8)) << COEF_FRAC) + HALF;

   function automatic int k(input int c);
      return c < 0 ? -(((-c) * (2 ** COEF_FRAC) + 5000) / 10000)
                   : (c * (2 ** COEF_FRAC) + 5000) / 10000;
   endfunction

   // Rounded magnitudes with the sign reapplied; order is Y(r,g,b), Cb(r,g,b), Cr(r,g,b)
   localparam int KF [9] = '{k(2990), k(5870), k(1140), k(-1687), k(-3313), k(5000),
                             k(5000), k(-4187), k(-813)};
   localparam int KS [9] = '{k(2568), k(5041), k(979), k(-1482), k(-2910), k(4392),
                             k(4392), k(-3678), k(-714)};

   function automatic logic [DATA_W-1:0] sat(input logic signed [AW-1:0] x);
      logic signed [AW-1:0] t;
      t = x >>> COEF_FRAC;
      return t[AW-1] ? '0 : |t[AW-2:DATA_W] ? '1 : t[DATA_W-1:0];
   endfunction

   logic                     en, cur_full, full_q, m1;
   logic [2:0]               v, sof, eol;
   logic [DATA_W-1:0]        rgb [3];
   logic signed [AW-1:0]     p [9];
   logic signed [AW-1:0]     a [3];
   logic signed [AW-1:0]     b [3];
   logic signed [AW-1:0]     s [3];

   assign en       = !m_valid || m_ready;
   assign s_ready  = en;
   assign cur_full = s_valid && s_sof ? cfg_full_range : full_q;
   assign rgb[0]   = s_r;
   assign rgb[1]   = s_g;
   assign rgb[2]   = s_b;

   // The mode travels with each pixel so a frame switch never affects pixels already in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q  <= DEFAULT_FULL;
         m1      <= 1'b0;
         v       <= '0;
         sof     <= '0;
         eol     <= '0;
         m_valid <= 1'b0;
         m_y     <= '0;
         m_cb    <= '0;
         m_cr    <= '0;
         m_sof   <= 1'b0;
         m_eol   <= 1'b0;
         for (int i = 0; i < 9; i++) p[i] <= '0;
         for (int i = 0; i < 3; i++) begin
            a[i] <= '0;
            b[i] <= '0;
            s[i] <= '0;
         end
      end else if (en) begin
         if (s_valid && s_sof) full_q <= cfg_full_range;
         v   <= {v[1:0], s_valid};
         sof <= {sof[1:0], s_sof};
         eol <= {eol[1:0], s_eol};
         m1  <= cur_full;
         for (int i = 0; i < 9; i++)
            p[i] <= $signed({{(AW-DATA_W){1'b0}}, rgb[i%3]}) * $signed(AW'(cur_full ? KF[i] : KS[i]));
         for (int i = 0; i < 3; i++) begin
            a[i] <= p[3*i] + p[3*i+1];
            b[i] <= p[3*i+2] + $signed(AW'(i == 0 ? (m1 ? HALF : OFF_YS) : OFF_C));
            s[i] <= a[i] + b[i];
         end
         m_valid <= v[2];
         if (v[2]) begin
            m_y   <= sat(s[0]);
            m_cb  <= sat(s[1]);
            m_cr  <= sat(s[2]);
            m_sof <= sof[2];
            m_eol <= eol[2];
         end
      end
   end
endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// tb_rgb2ycbcr_pipe: table vectors plus a queue scoreboard fed by an integer colour model;
// covers latency, saturation, random stalls, per-frame mode switching and async reset.
module tb_rgb2ycbcr_pipe;
   logic       clk = 1'b0, rst_n = 1'b0, cfg = 1'b1;
   logic       s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0, m_ready = 1'b1;
   logic [7:0] s_r = '0, s_g = '0, s_b = '0;
   logic       s_ready, m_valid, m_sof, m_eol;
   logic [7:0] m_y, m_cb, m_cr;

   rgb2ycbcr_pipe dut (
      .clk(clk), .rst_n(rst_n), .cfg_full_range(cfg),
      .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_g(s_g), .s_b(s_b),
      .s_sof(s_sof), .s_eol(s_eol),
      .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_cb(m_cb), .m_cr(m_cr),
      .m_sof(m_sof), .m_eol(m_eol)
   );

   always #5 clk = ~clk;

   typedef struct {logic [7:0] y, cb, cr; logic sof, eol;} px_t;
   typedef struct {logic [7:0] r, g, b; logic full; logic [7:0] y, cb, cr;} vec_t;

   px_t         q[$];
   px_t         e;
   vec_t        tv[8];
   int          n_chk = 0, n_fail = 0, n_out = 0, n_acc = 0;
   logic        tb_full = 1'b1, acc_flag = 1'b0, prev_stall = 1'b0;
   logic [25:0] prev_bus = '0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int clamp8(input int x);
      int t = x >>> 8;
      return t < 0 ? 0 : t > 255 ? 255 : t;
   endfunction

   function automatic px_t model(input logic [7:0] r, g, b, input logic full, sof, eol);
      int  ir = int'(r), ig = int'(g), ib = int'(b);
      px_t o;
      if (full) begin
         o.y  = 8'(clamp8(77*ir + 150*ig + 29*ib + 128));
         o.cb = 8'(clamp8(-43*ir - 85*ig + 128*ib + 32896));
         o.cr = 8'(clamp8(128*ir - 107*ig - 21*ib + 32896));
      end else begin
         o.y  = 8'(clamp8(66*ir + 129*ig + 25*ib + 4224));
         o.cb = 8'(clamp8(-38*ir - 74*ig + 112*ib + 32896));
         o.cr = 8'(clamp8(112*ir - 94*ig - 18*ib + 32896));
      end
      o.sof = sof;
      o.eol = eol;
      return o;
   endfunction

   // Handshakes are decided here, half a cycle before the edge that commits them
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         tb_full    = 1'b1;
         prev_stall = 1'b0;
         acc_flag   = 1'b0;
      end else begin
         acc_flag = s_valid && s_ready;
         if (acc_flag) begin
            if (s_sof) tb_full = cfg;
            q.push_back(model(s_r, s_g, s_b, tb_full, s_sof, s_eol));
            n_acc++;
         end
         if (prev_stall) begin
            chk("stall_valid", int'(m_valid), 1);
            chk("stall_hold", int'({m_y, m_cb, m_cr, m_sof, m_eol}), int'(prev_bus));
         end
         if (m_valid && m_ready) begin
            if (q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               e = q.pop_front();
               chk("sb_y", int'(m_y), int'(e.y));
               chk("sb_cb", int'(m_cb), int'(e.cb));
               chk("sb_cr", int'(m_cr), int'(e.cr));
               chk("sb_sof", int'(m_sof), int'(e.sof));
               chk("sb_eol", int'(m_eol), int'(e.eol));
               n_out++;
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_bus   = {m_y, m_cb, m_cr, m_sof, m_eol};
      end
   end

   task automatic drive(input logic v, input logic [7:0] r, g, b, input logic sof, eol, c);
      s_valid = v; s_r = r; s_g = g; s_b = b; s_sof = sof; s_eol = eol; cfg = c;
   endtask

   task automatic run_vec(input vec_t v, input logic sof, input string nm);
      int lat;
      @(posedge clk); #1;
      drive(1'b1, v.r, v.g, v.b, sof, 1'b1, v.full);
      m_ready = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      lat = 1;
      while (!m_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_latency"}, lat, 4);
      chk({nm, "_y"}, int'(m_y), int'(v.y));
      chk({nm, "_cb"}, int'(m_cb), int'(v.cb));
      chk({nm, "_cr"}, int'(m_cr), int'(v.cr));
   endtask

   task automatic drain(input string nm);
      int cyc = 0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      while ((q.size() > 0 || m_valid) && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({nm, "_drain_empty"}, q.size(), 0);
      chk({nm, "_out_count"}, n_out, n_acc);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent, cyc, quiet;
      logic [7:0] r, g, b;
      tv[0] = '{8'd255, 8'd255, 8'd255, 1'b1, 8'd255, 8'd128, 8'd128};
      tv[1] = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd0,   8'd128, 8'd128};
      tv[2] = '{8'd0,   8'd0,   8'd0,   1'b0, 8'd16,  8'd128, 8'd128};
      tv[3] = '{8'd255, 8'd255, 8'd255, 1'b0, 8'd235, 8'd128, 8'd128};
      tv[4] = '{8'd0,   8'd0,   8'd255, 1'b1, 8'd29,  8'd255, 8'd107};
      tv[5] = '{8'd255, 8'd0,   8'd0,   1'b1, 8'd77,  8'd85,  8'd255};
      tv[6] = '{8'd0,   8'd255, 8'd0,   1'b1, 8'd149, 8'd43,  8'd21};
      tv[7] = '{8'd255, 8'd0,   8'd0,   1'b0, 8'd82,  8'd90,  8'd240};

      #12;
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'({m_y, m_cb, m_cr, m_sof, m_eol}), 0);
      chk("rst_s_ready", int'(s_ready), 1);
      #10 rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(tv[i], 1'b1, $sformatf("vec%0d", i));
      drain("vec");

      // Random valid/ready; the pending pixel is held until it is accepted
      sent = 0; cyc = 0;
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      while (sent < 1000 && cyc < 20000) begin
         drive(1'($urandom % 2), r, g, b, sent % 50 == 0, sent % 10 == 9, 1'($urandom % 2));
         m_ready = 1'($urandom % 2);
         @(posedge clk); #1;
         cyc++;
         if (acc_flag) begin
            sent++;
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
         end
      end
      chk("rand_sent", sent, 1000);
      drain("rand");

      // Back-to-back frames alternating mode; a mid-frame cfg flip must be ignored
      for (int f = 0; f < 6; f++)
         for (int p = 0; p < 4; p++) begin
            drive(1'b1, (p == 0 || p == 3) ? 8'd255 : 8'($urandom),
                  (p == 0 || p == 3) ? 8'd255 : 8'($urandom),
                  (p == 0 || p == 3) ? 8'd255 : 8'($urandom),
                  p == 0, p == 3, p == 2 ? 1'(f % 2 == 0) : 1'(f % 2));
            m_ready = 1'b1;
            @(posedge clk); #1;
         end
      drain("frames");

      // Async reset with one pixel at the output and three in flight
      for (int p = 0; p < 4; p++) begin
         drive(1'b1, 8'd255, 8'd255, 8'd255, p == 0, 1'b0, 1'b0);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      chk("pre_rst_valid", int'(m_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_m_valid", int'(m_valid), 0);
      chk("arst_m_y", int'(m_y), 0);
      chk("arst_m_cb", int'(m_cb), 0);
      chk("arst_m_cr", int'(m_cr), 0);
      chk("arst_m_side", int'({m_sof, m_eol}), 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      quiet = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         quiet += int'(m_valid);
      end
      chk("post_rst_no_ghost", quiet, 0);
      n_out = 0; n_acc = 0;
      run_vec('{8'd255, 8'd255, 8'd255, 1'b0, 8'd255, 8'd128, 8'd128}, 1'b0, "post_rst");
      drain("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
